// File: rtl/bist_tpg_ctrl_pkg.sv
// Shared BIST definitions: controller state encoding and default LFSR constants.
// Also consumed by the MISR side of the BIST chain.
package bist_tpg_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } tpg_state_e;

  localparam logic [7:0] BIST_POLY = 8'hB8;
  localparam logic [7:0] BIST_SEED = 8'h01;

endpackage

// File: rtl/bist_lfsr_galois.sv
// Right-shifting Galois LFSR with synchronous load (load wins over step).
module bist_lfsr_galois
  import bist_tpg_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY = BIST_POLY,
  parameter logic [WIDTH-1:0] SEED = BIST_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_nxt;

  assign q_nxt = (q >> 1) ^ (q[0] ? POLY : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED;
    end else if (load) begin
      q <= load_val;
    end else if (step) begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/bist_tpg_ctrl.sv
// BIST test pattern generator and sequencer with delayed MISR capture enable.
// Define TPG_ALL_ZERO_EN to append one all-zero pattern to every run.
module bist_tpg_ctrl
  import bist_tpg_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY = BIST_POLY,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = BIST_SEED,
  parameter int NUM_PATTERNS = 255,
  parameter int CUT_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] pattern,
  output logic             pattern_valid,
  output logic             misr_en,
  output logic             busy,
  output logic             done
);

  localparam int CW = WIDTH + 1;
  localparam int DL = (CUT_LATENCY == 0) ? 1 : CUT_LATENCY;
  localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS - 1);

  tpg_state_e state, state_nxt;

  logic [WIDTH-1:0] seed_reg, seed_nz, lfsr_q, lfsr_ld;
  logic [CW-1:0]    count;
  logic [DL-1:0]    dl, dl_nxt;
  logic             can_start, go, sload, issue;
  logic             last, zero_pat, pending;

  assign seed_nz   = (seed == '0) ? DEFAULT_SEED : seed;
  assign can_start = (state == IDLE) || (state == DONE);
  assign go        = can_start & start & ~abort;
  assign sload     = can_start & seed_load & ~abort;
  assign issue     = (state == RUN) & ~hold & ~abort;
  assign lfsr_ld   = seed_load ? seed_nz : seed_reg;

`ifdef TPG_ALL_ZERO_EN
  localparam logic [CW-1:0] ZIDX = CW'(NUM_PATTERNS);
  assign zero_pat = (count == ZIDX);
  assign last     = zero_pat;
`else
  assign zero_pat = 1'b0;
  assign last     = (count == LAST);
`endif

  // pending: a valid still has to reach misr_en after the coming edge
  generate
    if (CUT_LATENCY == 0) begin : g_lat0
      assign dl_nxt  = '0;
      assign misr_en = pattern_valid;
      assign pending = 1'b0;
    end else if (CUT_LATENCY == 1) begin : g_lat1
      assign dl_nxt  = pattern_valid;
      assign misr_en = dl[0];
      assign pending = pattern_valid;
    end else begin : g_latn
      assign dl_nxt  = {dl[DL-2:0], pattern_valid};
      assign misr_en = dl[DL-1];
      assign pending = pattern_valid | (|dl[DL-2:0]);
    end
  endgenerate

  bist_lfsr_galois #(
    .WIDTH(WIDTH),
    .POLY (POLY),
    .SEED (DEFAULT_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (go),
    .load_val(lfsr_ld),
    .step    (issue & ~zero_pat),
    .q       (lfsr_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      abort:                         state_nxt = IDLE;
      go:                            state_nxt = RUN;
      issue && last:                 state_nxt = DRAIN;
      (state == DRAIN) && !pending:  state_nxt = DONE;
      default:                       state_nxt = state;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN, DRAIN: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seed_reg      <= DEFAULT_SEED;
      count         <= '0;
      pattern       <= '0;
      pattern_valid <= 1'b0;
      dl            <= '0;
    end else begin
      if (sload) begin
        seed_reg <= seed_nz;
      end
      if (abort) begin
        pattern_valid <= 1'b0;
        dl            <= '0;
      end else begin
        if (go) begin
          count <= '0;
        end
        if (issue) begin
          pattern <= zero_pat ? '0 : lfsr_q;
          count   <= count + 1'b1;
        end
        pattern_valid <= issue;
        dl            <= dl_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bist_tpg_ctrl.sv
// Directed bench for bist_tpg_ctrl (WIDTH=8, 255 patterns, CUT latency 1).
module tb_bist_tpg_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       hold = 1'b0;
  logic       seed_load = 1'b0;
  logic [7:0] seed = 8'h00;
  logic [7:0] pattern;
  logic       pattern_valid, misr_en, busy, done;

  int n_checks = 0;
  int n_errors = 0;

`ifdef TPG_ALL_ZERO_EN
  localparam int NEXP = 256;
  localparam int ZEXP = 1;
  localparam logic [7:0] LASTP = 8'h00;
`else
  localparam int NEXP = 255;
  localparam int ZEXP = 0;
  localparam logic [7:0] LASTP = 8'h02;
`endif

  bist_tpg_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .hold         (hold),
    .seed_load    (seed_load),
    .seed         (seed),
    .pattern      (pattern),
    .pattern_valid(pattern_valid),
    .misr_en      (misr_en),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int         cyc, npv, nmisr, ndup, nzero, nmis, last_m, done_at;
  logic [7:0] last_pat;
  logic       pv_q, done_q;
  bit [255:0] seen;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    npv = 0; nmisr = 0; ndup = 0; nzero = 0; nmis = 0;
    last_m = -1; done_at = -1; seen = '0;
  endtask

  // advance to the next falling edge and update run statistics
  task automatic step();
    @(negedge clk);
    cyc++;
    if (misr_en !== pv_q) nmis++;
    pv_q = pattern_valid;
    if (pattern_valid) begin
      npv++;
      if (seen[pattern]) ndup++;
      seen[pattern] = 1'b1;
      if (pattern == 8'h00) nzero++;
      last_pat = pattern;
    end
    if (misr_en) begin
      nmisr++;
      last_m = cyc;
    end
    if (done && !done_q) done_at = cyc;
    done_q = done;
  endtask

  task automatic begin_run(input logic ld, input logic [7:0] sd);
    start = 1'b1; seed_load = ld; seed = sd;
    step();
    start = 1'b0; seed_load = 1'b0;
    step();
  endtask

  task automatic finish_run(input string tag);
    for (int i = 0; i < 2000 && !done; i++) step();
    check({tag, "_done"}, done, 1);
    step();
    check({tag, "_npv"}, npv, NEXP);
    check({tag, "_nmisr"}, nmisr, NEXP);
    check({tag, "_dup"}, ndup, 0);
    check({tag, "_zero"}, nzero, ZEXP);
    check({tag, "_align"}, nmis, 0);
    check({tag, "_donerise"}, done_at, last_m + 1);
    check({tag, "_lastpat"}, last_pat, LASTP);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [7:0] exp_seq [6];
    exp_seq = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    cyc = 0; pv_q = 1'b0; done_q = 1'b0; last_pat = 8'h00;
    clr();

    step(); step();
    check("rst_pattern", pattern, 8'h00);
    check("rst_valid", pattern_valid, 0);
    check("rst_misr", misr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    step();

    // run 1: default seed, sequence and latency
    clr();
    start = 1'b1;
    step();
    start = 1'b0;
    check("r1_busy", busy, 1);
    check("r1_valid_t1", pattern_valid, 0);
    step();
    for (int i = 0; i < 6; i++) begin
      check("r1_valid", pattern_valid, 1);
      check("r1_pattern", pattern, exp_seq[i]);
      check("r1_misr", misr_en, (i == 0) ? 0 : 1);
      step();
    end
    finish_run("r1");

    // run 2: restart repeats, hold for 3 cycles after 5C
    clr();
    begin_run(1'b0, 8'h00);
    check("r2_first", pattern, 8'h01);
    step(); step();
    check("r2_pre_hold", pattern, 8'h5C);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("r2_hold_valid", pattern_valid, 0);
      check("r2_hold_pat", pattern, 8'h5C);
    end
    hold = 1'b0;
    step();
    check("r2_resume", pattern, 8'h2E);
    check("r2_resume_v", pattern_valid, 1);
    finish_run("r2");

    // start + seed_load together from DONE uses the new seed
    begin_run(1'b1, 8'h5A);
    check("r3_first", pattern, 8'h5A);
    step();
    check("r3_second", pattern, 8'h2D);
    seed_load = 1'b1; seed = 8'h33;
    step();
    seed_load = 1'b0;
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    check("abort_valid", pattern_valid, 0);
    check("abort_misr", misr_en, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    step();
    check("abort_idle", busy, 0);

    // seed_reg kept across abort; seed_load in RUN was ignored
    begin_run(1'b0, 8'h00);
    check("r4_first", pattern, 8'h5A);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // zero seed substitutes the default seed
    seed_load = 1'b1; seed = 8'h00;
    step();
    seed_load = 1'b0;
    begin_run(1'b0, 8'h00);
    check("r5_zero_seed", pattern, 8'h01);
    step(); step();

    // asynchronous reset mid-run
    rst = 1'b0;
    #1;
    check("mrst_valid", pattern_valid, 0);
    check("mrst_misr", misr_en, 0);
    check("mrst_busy", busy, 0);
    check("mrst_pattern", pattern, 8'h00);
    step();
    check("mrst_misr2", misr_en, 0);
    rst = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
